// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction prefetch buffer in front of the IF stage.
// Fetches 32-bit words through a single-outstanding req/ack port and keeps
// up to DEPTH {pc, inst} pairs in a circular buffer for the integer unit.
//
// Handshake: imem_req/imem_addr are registered and held stable until an
// imem_ack is sampled on a rising edge while imem_req=1; one word per cycle
// is accepted when ack is held high. A request is only launched when the
// queue will have a free slot, so an accepted word always fits.
//
// Optional feature: define IPQ_BYPASS_EN to forward an acked word straight
// to valid/pc/inst in the same cycle when the queue is empty.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     clrn,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic                     valid,
    output logic [31:0]              pc,
    output logic [31:0]              inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];

    logic [31:0]       rpc;
    logic              q_valid;
    logic              accept;
    logic              bypass_hit;
    logic              push;
    logic              pop;
    logic              space;
    logic [31:0]       target;

    // Queue bookkeeping: decide push/pop and the next pointers and occupancy.
    always_comb begin
        rpc     = redirect_pc & 32'hFFFF_FFFC;
        q_valid = (count_q != '0);
        accept  = req_q && imem_ack && !redirect && (state_q == FETCH);
`ifdef IPQ_BYPASS_EN
        bypass_hit = accept && !q_valid;
`else
        bypass_hit = 1'b0;
`endif
        // A word consumed through the bypass never lands in the buffer.
        push = accept && !(bypass_hit && deq);
        pop  = deq && q_valid && !redirect;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_ONE;
            if (pop)  head_d = head_q + PTR_ONE;
            if (push && !pop) count_d = count_q + CNT_ONE;
            if (pop && !push) count_d = count_q - CNT_ONE;
        end
        space = (count_d < CNT_FULL);
    end

    // Fetch FSM next-state: request launch, hold, stale-drop and redirect.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        target     = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = rpc;
                    state_d    = FETCH;
                    req_d      = 1'b1;
                    addr_d     = rpc;
                end else if (space) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Word from the old stream is dropped on the floor.
                        fetch_pc_d = rpc;
                        addr_d     = rpc;
                        req_d      = 1'b1;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (space) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // Request must stay stable until acked; remember where to go.
                    state_d   = DROP;
                    pend_pc_d = rpc;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    target     = redirect ? rpc : pend_pc_q;
                    fetch_pc_d = target;
                    if (space) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = target;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    pend_pc_d = rpc;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request and queue control registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= 32'h0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only visible when count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= addr_q;
            inst_mem[tail_q] <= imem_data;
        end
    end

    // Head presentation: empty queue shows pc=0 and a NOP.
    always_comb begin
        valid = q_valid || bypass_hit;
        pc    = 32'h0;
        inst  = 32'h0;
        if (q_valid) begin
            pc   = pc_mem[head_q];
            inst = inst_mem[head_q];
        end else if (bypass_hit) begin
            pc   = addr_q;
            inst = imem_data;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios followed by random traffic,
// checked each cycle against a queue-based model of the fetch stream.
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          EW       = 1 + 32 + 1 + 32 + 32 + CW;

  logic          clk;
  logic          clrn;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          deq;
  logic          valid;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic [CW-1:0] count;
  logic [1:0]    state_dbg;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .clrn(clrn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq(deq), .valid(valid), .pc(pc), .inst(inst),
    .count(count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: the program stream and the buffered words.
  logic [63:0] mq[$];
  logic [31:0] stream_pc;
  logic [31:0] m_addr;
  logic        m_req;
  logic        stale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of the reference: redirect flushes everything, a request
  // outstanding at a redirect returns a word that is thrown away, a good
  // word is appended, the head is consumed when present, and a new request
  // goes out whenever the buffer has room.
  task automatic model_step();
    logic        acked;
    logic        do_pop;
    logic [63:0] front;
    logic [EW-1:0] e;
    if (!clrn) begin
      mq.delete();
      stream_pc = RESET_PC;
      m_req     = 1'b0;
      m_addr    = 32'h0;
      stale     = 1'b0;
    end else begin
      acked = m_req && imem_ack;
      if (redirect) begin
        mq.delete();
        stream_pc = {redirect_pc[31:2], 2'b00};
        stale     = m_req && !imem_ack;
      end else begin
        do_pop = deq && (mq.size() > 0);
        if (acked) begin
          if (stale) stale = 1'b0;
          else begin
            mq.push_back({m_addr, imem_data});
            stream_pc = m_addr + 32'd4;
          end
        end
        if (do_pop) void'(mq.pop_front());
      end
      if (m_req && !imem_ack) begin
        // request still outstanding: address held
      end else if (mq.size() < DEPTH) begin
        m_req  = 1'b1;
        m_addr = stream_pc;
      end else begin
        m_req = 1'b0;
      end
    end
    front = (mq.size() > 0) ? mq[0] : 64'h0;
    e = {m_req, m_addr, (mq.size() > 0), front[63:32], front[31:0], CW'(mq.size())};
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: pops one expectation per clock and compares the DUT outputs.
  initial begin
    logic [EW-1:0] e;
    logic          e_req;
    logic [31:0]   e_addr;
    logic          e_valid;
    logic [31:0]   e_pc;
    logic [31:0]   e_inst;
    logic [CW-1:0] e_cnt;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        {e_req, e_addr, e_valid, e_pc, e_inst, e_cnt} = e;
        chk("mon_imem_req", {31'h0, imem_req}, {31'h0, e_req});
        if (e_req) chk("mon_imem_addr", imem_addr, e_addr);
        chk("mon_valid", {31'h0, valid}, {31'h0, e_valid});
        chk("mon_pc", pc, e_pc);
        chk("mon_inst", inst, e_inst);
        chk("mon_count", 32'(count), 32'(e_cnt));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #3;
    imem_data = $urandom;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},   {31'h0, imem_req}, 32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_inst"},  inst, 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
  endtask

  int ack_pct [4] = '{90, 50, 100, 30};
  int deq_pct [4] = '{20, 50, 10, 90};

  // ---------------- stimulus ----------------
  initial begin
    clrn        = 1'b1;
    imem_ack    = 1'b0;
    imem_data   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq         = 1'b0;
    #1 clrn = 1'b0;
    tick(); tick(); tick();
    chk_zero_outputs("reset");

    // Zero-wait fill: 0,4,8,12 on consecutive cycles, then the request drops.
    clrn     = 1'b1;
    imem_ack = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("fill_req", {31'h0, imem_req}, 32'h1);
      chk("fill_addr", imem_addr, 32'(4 * i));
      tick();
    end
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_pc", pc, 32'h0);

    // One dequeue from full reopens fetching at 16.
    deq      = 1'b1;
    imem_ack = 1'b0;
    tick();
    deq = 1'b0;
    chk("deq1_count", 32'(count), 32'd3);
    chk("deq1_pc", pc, 32'h4);
    chk("deq1_req", {31'h0, imem_req}, 32'h1);
    chk("deq1_addr", imem_addr, 32'h10);

    // Redirect together with ack: word dropped, queue flushed.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0008;
    imem_ack    = 1'b1;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b0;
    chk("rdack_count", 32'(count), 32'h0);
    chk("rdack_valid", {31'h0, valid}, 32'h0);
    chk("rdack_addr", imem_addr, 32'h8);

    // Redirect to 0x100 while the fetch of 0x8 waits three cycles for ack.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_hold_addr", imem_addr, 32'h8);
      chk("drop_hold_valid", {31'h0, valid}, 32'h0);
      if (i < 2) tick();
    end
    imem_ack = 1'b1;
    tick();
    chk("drop_next_addr", imem_addr, 32'h100);
    chk("drop_count", 32'(count), 32'h0);
    tick();
    imem_ack = 1'b0;
    chk("drop_first_valid", {31'h0, valid}, 32'h1);
    chk("drop_first_pc", pc, 32'h100);

    // Dequeue held while empty: no underflow.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    deq         = 1'b1;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("empty_deq_count", 32'(count), 32'h0);
      chk("empty_deq_valid", {31'h0, valid}, 32'h0);
      chk("empty_deq_inst", inst, 32'h0);
      tick();
    end
    deq = 1'b0;

    // Build up three entries, then pulse reset mid-stream.
    imem_ack = 1'b1;
    repeat (4) tick();
    imem_ack = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_pc", pc, 32'h200);
    clrn = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    tick();
    clrn = 1'b1;
    tick();
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, RESET_PC);

    // Random traffic in phases with different memory/consumer behaviour.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        imem_ack    = ($urandom_range(0, 99) < ack_pct[ph]);
        deq         = ($urandom_range(0, 99) < deq_pct[ph]);
        redirect    = ($urandom_range(0, 19) == 0);
        redirect_pc = $urandom;
        if ($urandom_range(0, 299) == 0) begin
          clrn = 1'b0;
          tick();
          clrn = 1'b1;
        end
        tick();
      end
    end
    imem_ack = 1'b0;
    deq      = 1'b0;
    redirect = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue upstream of the integer unit's IF stage. It fetches 32-bit words from instruction memory through a single-outstanding req/ack handshake and buffers up to DEPTH fetched {pc, inst} pairs. It presents the head entry to the integer unit, which consumes it when the pipeline is not stalled. Branch/jump redirects flush the queue, and an in-flight fetch from the old stream is discarded.

## Interface
- DEPTH, 4, queue entries (power of two, 2..16)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address, word aligned, registered
- imem_ack  in  1  memory returns imem_data this cycle
- imem_data  in  32  fetched instruction
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced 0)
- deq  in  1  IU consumes head entry (driven as ~stl)
- valid  out  1  head entry present
- pc  out  32  pc of head entry
- inst  out  32  head instruction
- count  out  log2(DEPTH)+1  occupied entries

## Operation
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus count.
- FSM states: IDLE (no request), FETCH (imem_req=1, awaiting ack), DROP (imem_req=1, awaiting ack for stale address).
- Capacity reservation: a request is issued only if count_next < DEPTH, so an accepted ack always has a free slot; no overflow is possible.
- IDLE -> FETCH when count_next < DEPTH. The fetch address is fetch_pc.
- FETCH with imem_ack: push {imem_addr, imem_data}, fetch_pc += 4 (mod 2^32). Stay in FETCH with the new address if count_next < DEPTH, else -> IDLE.
- FETCH with redirect and no ack -> DROP. Save redirect_pc as pending target. imem_req and imem_addr are held.
- DROP with imem_ack: discard data, fetch_pc <= pending target, -> FETCH (or IDLE if full; cannot occur after flush).
- Redirect in DROP: pending target overwritten with the newest redirect_pc.
- Redirect and imem_ack in the same cycle, in FETCH or DROP: data discarded. fetch_pc <= redirect_pc, -> FETCH.
- Redirect in IDLE: fetch_pc <= redirect_pc, -> FETCH.
- Redirect always clears count, head and tail, and overrides deq in the same cycle.
- deq with valid=0 is ignored. Simultaneous deq and push: count unchanged, both pointers advance.
- Empty outputs: valid=0, pc=0, inst=32'h0000_0000 (NOP).

## Timing
- Reset (clrn=0, asynchronous):
  - imem_req=0, imem_addr=0, valid=0, pc=0, inst=0, count=0
  - state=IDLE, fetch_pc=RESET_PC, pointers 0
- Handshake:
  - imem_addr stable while imem_req=1 until ack is sampled.
  - imem_ack is sampled at the rising edge and is meaningful only while imem_req=1.
  - With ack held high, one word is accepted per cycle.
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after clrn rises.
- Latency: data acked at edge N appears on valid/pc/inst after edge N (registered, one cycle).
- Redirect at edge N, no request in flight: imem_addr=redirect_pc after edge N. valid=0 until the first new ack is registered.
- Reset asserted mid-fetch: the request is dropped immediately. The memory must tolerate an aborted request.

## Configuration
- IPQ_BYPASS_EN defined:
  - When the queue is empty, state=FETCH, imem_ack=1 and redirect=0, imem_data and imem_addr drive inst and pc combinationally with valid=1 in the same cycle.
  - If deq=1 that cycle, the word is consumed and not written.
  - This is a zero-cycle fetch-to-IU path.
- Undefined: all outputs come from the registered queue, and latency is one cycle as above.

## Test plan
- Reset release, zero-wait memory (ack=1), deq=0:
  - addresses 0,4,8,12 are fetched on consecutive cycles, then imem_req drops.
  - count=4, head pc=0.
- Full queue, deq=1 for one cycle -> count=3, pc=4; imem_req reasserts next cycle with addr=16.
- Redirect to 0x100 while a fetch of 0x8 is pending with ack delayed 3 cycles:
  - imem_addr holds 0x8 until ack, and that data is discarded.
  - The next request is at 0x100, and the first valid pc is 0x100.
- Redirect and ack in the same cycle -> data dropped, count=0, next imem_addr=redirect_pc.
- deq asserted continuously while empty -> no underflow; count stays 0, valid=0, inst=0.
- clrn pulsed low mid-stream with count=3 -> all outputs are 0 immediately, and fetch restarts at RESET_PC.
